// File: rtl/conv_fprop3_mac_pipe.sv
// Pipelined multiply-accumulate for the conv_fprop3 datapath.
// Product pipeline of NUM_STAGE registers feeds a framed accumulator
// (first/last) and a rounded, saturated output register. A single
// advance enable moves every register at once; there is no skid buffer.
// Expected parameter ranges: ACC_WIDTH >= din0_WIDTH + din1_WIDTH and
// ACC_WIDTH >= dout_WIDTH >= 2.
module conv_fprop3_mac_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int SHIFT      = 16,
  parameter int dout_WIDTH = 32,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  first,
  input  logic                  last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int DW = dout_WIDTH;
  // Round-half-up constant added before the output shift.
  localparam logic [AW:0] RND =
    (SHIFT > 0) ? ((AW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  logic          advance;
  logic [PW-1:0] op0_ext, op1_ext, prod_pw;
  logic          op0_s, op1_s, prod_s;
  logic [AW-1:0] prod_acc;

  logic [AW-1:0]        prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0] vld_q, first_q, last_q;

  logic          vld_t, first_t, last_t, load;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW:0]   acc_x, sum, r;
  logic          fits;
  logic [DW-1:0] dout_q, dout_d;
  logic          ovf_q, ovf_d, out_valid_q;

  assign advance  = ce && (!out_valid_q || out_ready);
  assign in_ready = advance && !reset;

  // Extend operands to the full product width so one multiplier serves
  // both signed and unsigned modes (low PW bits are mode-agnostic).
  always_comb begin
    op0_s   = (SIGNED != 0) && din0[din0_WIDTH-1];
    op1_s   = (SIGNED != 0) && din1[din1_WIDTH-1];
    op0_ext = {{din1_WIDTH{op0_s}}, din0};
    op1_ext = {{din0_WIDTH{op1_s}}, din1};
    prod_pw = op0_ext * op1_ext;
    prod_s  = (SIGNED != 0) && prod_pw[PW-1];
  end

  generate
    if (AW > PW) begin : g_ext
      assign prod_acc = {{(AW-PW){prod_s}}, prod_pw};
    end else begin : g_trunc
      assign prod_acc = prod_pw[AW-1:0];
    end
  endgenerate

  // Product pipeline: data plus valid/first/last framing, bubbles included.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
    end else if (advance) begin
      prod_q[0]  <= prod_acc;
      vld_q[0]   <= in_valid;
      first_q[0] <= first;
      last_q[0]  <= last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i]  <= prod_q[i-1];
        vld_q[i]   <= vld_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign vld_t   = vld_q[NUM_STAGE-1];
  assign first_t = first_q[NUM_STAGE-1];
  assign last_t  = last_q[NUM_STAGE-1];
  assign load    = vld_t && last_t;

  // Accumulate, round, shift and saturate the post-update accumulator.
  always_comb begin
    acc_d = first_t ? prod_q[NUM_STAGE-1] : acc_q + prod_q[NUM_STAGE-1];
    acc_x = {(SIGNED != 0) && acc_d[AW-1], acc_d};
    sum   = acc_x + RND;
    if (SIGNED != 0) r = $signed(sum) >>> SHIFT;
    else             r = sum >> SHIFT;
    dout_d = r[DW-1:0];
    ovf_d  = 1'b0;
    if (SIGNED != 0) begin
      fits = (&r[AW:DW-1]) || !(|r[AW:DW-1]);
      if (!fits) begin
        ovf_d  = 1'b1;
        dout_d = r[AW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
    end else begin
      fits = !(|r[AW:DW]);
      if (!fits) begin
        ovf_d  = 1'b1;
        dout_d = '1;
      end
    end
  end

  // Accumulator and output register; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      if (vld_t) acc_q <= acc_d;
      out_valid_q <= load;
      if (load) begin
        dout_q <= dout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule
